// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - time-multiplexed single-MAC FIR filter with circular delay line
module fir_mac_engine #(
   parameter int NTAPS      = 64,
   parameter int DATA_WIDTH = 18,
   parameter int COEF_WIDTH = 16,
   parameter int COEF_FRAC  = 15,
   parameter int ACC_WIDTH  = 41
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  data_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [6:0]            coef_addr,
   input  logic [COEF_WIDTH-1:0] coef_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  overrun
);
   localparam int PTR_W      = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      ACC_WIDTH'(-(64'sd1 <<< (DATA_WIDTH - 1)));

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

   state_t                        state;
   logic                          drain_last;
   logic [PTR_W-1:0]              wr_ptr;
   logic [PTR_W-1:0]              rd_idx;
   logic [7:0]                    rd_sum;
   logic signed [DATA_WIDTH-1:0]  delay_line [NTAPS];
   logic signed [DATA_WIDTH-1:0]  sample_q;
   logic signed [PROD_WIDTH-1:0]  prod_q;
   logic signed [ACC_WIDTH-1:0]   acc;
   logic signed [ACC_WIDTH-1:0]   acc_shift;
   logic signed [DATA_WIDTH-1:0]  sat_val;
   logic                          prod_en;
   logic                          acc_en;

   // coef_addr doubles as the tap index k; modulo done by compare-subtract so any NTAPS wraps correctly
   always_comb begin
      rd_sum = 8'(wr_ptr) + 8'(NTAPS) - 8'(coef_addr);
      rd_idx = (rd_sum >= 8'(NTAPS)) ? PTR_W'(rd_sum - 8'(NTAPS)) : PTR_W'(rd_sum);
   end

   always_comb begin
      acc_shift = acc >>> COEF_FRAC;
      if (acc_shift > SAT_MAX) begin
         sat_val = DATA_WIDTH'(SAT_MAX);
      end else if (acc_shift < SAT_MIN) begin
         sat_val = DATA_WIDTH'(SAT_MIN);
      end else begin
         sat_val = DATA_WIDTH'(acc_shift);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         drain_last <= 1'b0;
         wr_ptr     <= '0;
         coef_addr  <= '0;
         sample_q   <= '0;
         prod_q     <= '0;
         acc        <= '0;
         prod_en    <= 1'b0;
         acc_en     <= 1'b0;
         data_out   <= '0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < NTAPS; i++) begin
            delay_line[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         prod_en   <= (state == MAC);
         acc_en    <= prod_en;
         if (state == MAC) begin
            sample_q <= delay_line[rd_idx];
         end
         if (prod_en) begin
            prod_q <= PROD_WIDTH'(sample_q) * PROD_WIDTH'($signed(coef_data));
         end
         if (acc_en) begin
            acc <= acc + ACC_WIDTH'(prod_q);
         end
         // busy lingers one cycle into IDLE so the out_valid cycle still rejects a strobe
         if (data_en && (state != IDLE || busy)) begin
            overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (data_en && !busy) begin
                  delay_line[wr_ptr] <= $signed(data_in);
                  acc       <= '0;
                  coef_addr <= '0;
                  busy      <= 1'b1;
                  state     <= MAC;
               end
            end
            MAC: begin
               if (coef_addr == 7'(NTAPS - 1)) begin
                  drain_last <= 1'b0;
                  state      <= DRAIN;
               end else begin
                  coef_addr <= coef_addr + 7'd1;
               end
            end
            DRAIN: begin
               drain_last <= 1'b1;
               if (drain_last) begin
                  state <= DONE;
               end
            end
            DONE: begin
               data_out  <= sat_val;
               out_valid <= 1'b1;
               wr_ptr    <= (wr_ptr == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr + PTR_W'(1);
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine
module tb_fir_mac_engine;
   localparam int NT  = 64;
   localparam int LAT = NT + 4;

   typedef struct {
      int x;
      int exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        data_en = 1'b0;
   logic [17:0] data_in = '0;
   logic [6:0]  coef_addr;
   logic [15:0] coef_data;
   logic [17:0] data_out;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   logic signed [15:0] coef_mem [128];
   int   hist[$];
   int   total = 0;
   int   bad = 0;
   vec_t pos_vec[71];
   vec_t neg_vec[71];

   always #5 clk = ~clk;

   always @(posedge clk) coef_data <= coef_mem[coef_addr];

   fir_mac_engine dut (
      .clock(clk), .reset_n(reset_n), .data_en(data_en), .data_in(data_in),
      .coef_addr(coef_addr), .coef_data(coef_data), .data_out(data_out),
      .out_valid(out_valid), .busy(busy), .overrun(overrun)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int sdo();
      return int'($signed(data_out));
   endfunction

   task automatic push_sample(input int x);
      hist.push_back(x);
      if (hist.size() > NT) void'(hist.pop_front());
   endtask

   // y[n] = sat(floor(sum h[k]*x[n-k] / 2^15)) over the accepted-sample history
   function automatic int model_out();
      longint sum = 0;
      int n = hist.size();
      for (int k = 0; k < NT; k++) begin
         if (k < n) sum += longint'(coef_mem[k]) * longint'(hist[n-1-k]);
      end
      sum = sum >>> 15;
      if (sum > 131071) return 131071;
      if (sum < -131072) return -131072;
      return int'(sum);
   endfunction

   task automatic do_reset(input int n);
      @(negedge clk);
      reset_n = 1'b0;
      data_en = 1'b0;
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
      hist.delete();
   endtask

   task automatic strobe(input int x);
      @(negedge clk);
      data_in = 18'(x);
      data_en = 1'b1;
      push_sample(x);
   endtask

   task automatic send(input int x, input bit use_exp, input int exp, input string name);
      int lat;
      strobe(x);
      lat = 0;
      do begin
         @(negedge clk);
         data_en = 1'b0;
         lat++;
      end while (!out_valid && lat < 200);
      check({name, " latency"}, lat, LAT);
      check(name, sdo(), use_exp ? exp : model_out());
   endtask

   task automatic load_impulse_coefs();
      for (int k = 0; k < 128; k++) coef_mem[k] = (k < NT) ? 16'(256 * (k + 1)) : 16'd0;
   endtask

   initial begin
      int exp_v;
      int cnt;

      for (int n = 0; n < 71; n++) begin
         pos_vec[n].x   = (n == 0) ? 32768 : 0;
         pos_vec[n].exp = (n < NT) ? 256 * (n + 1) : 0;
         neg_vec[n].x   = (n == 0) ? -32768 : 0;
         neg_vec[n].exp = (n < NT) ? -256 * (n + 1) : 0;
      end
      load_impulse_coefs();

      // reset held 3 cycles with strobes that must be ignored
      data_en = 1'b1;
      data_in = 18'(5000);
      repeat (3) @(negedge clk);
      check("rst data_out", sdo(), 0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst overrun", overrun, 0);
      check("rst coef_addr", coef_addr, 0);
      reset_n = 1'b1;
      data_en = 1'b0;
      hist.delete();
      send(1000, 1'b1, 7, "first after reset");

      do_reset(2);
      for (int i = 0; i < 71; i++) send(pos_vec[i].x, 1'b1, pos_vec[i].exp, "impulse pos");
      for (int i = 0; i < 71; i++) send(neg_vec[i].x, 1'b1, neg_vec[i].exp, "impulse neg");

      // latency, busy window and coefficient address sequencing
      strobe(int'($urandom_range(0, 262143)) - 131072);
      exp_v = 0;
      for (int j = 1; j <= LAT + 2; j++) begin
         @(negedge clk);
         data_en = 1'b0;
         check("hs busy", busy, int'(j <= LAT));
         check("hs out_valid", out_valid, int'(j == LAT));
         check("hs coef_addr", coef_addr, (j <= NT) ? j - 1 : NT - 1);
         if (j == LAT) exp_v = model_out();
         if (j >= LAT) check("hs data_out", sdo(), exp_v);
      end
      check("hs overrun", overrun, 0);

      for (int k = 0; k < NT; k++) coef_mem[k] = 16'sd32767;
      for (int i = 0; i < NT; i++) send(131071, 1'b0, 0, "sat pos seq");
      check("sat pos final", sdo(), 131071);
      for (int i = 0; i < NT; i++) send(-131072, 1'b0, 0, "sat neg seq");
      check("sat neg final", sdo(), -131072);

      // second strobe at T+10 is dropped and flags overrun from T+11
      do_reset(2);
      strobe(40000);
      for (int j = 1; j <= LAT; j++) begin
         @(negedge clk);
         data_en = (j == 10);
         data_in = 18'(77777);
         check("ovr flag", overrun, int'(j >= 11));
         if (j == LAT) begin
            check("ovr out_valid", out_valid, 1);
            check("ovr data_out", sdo(), model_out());
         end
      end
      data_en = 1'b0;
      for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 262143)) - 131072, 1'b0, 0, "ovr after");
      check("ovr sticky", overrun, 1);

      // strobe on the out_valid cycle itself is still rejected
      do_reset(2);
      strobe(-20000);
      for (int j = 1; j <= LAT + 1; j++) begin
         @(negedge clk);
         data_en = (j == LAT);
         data_in = 18'(-5000);
      end
      check("edge overrun", overrun, 1);
      check("edge busy", busy, 0);
      send(12345, 1'b0, 0, "edge next sample");

      // strobe one cycle after out_valid is accepted cleanly
      do_reset(2);
      strobe(30000);
      for (int j = 1; j <= LAT; j++) begin
         @(negedge clk);
         data_en = 1'b0;
      end
      check("b2b first valid", out_valid, 1);
      send(-30000, 1'b0, 0, "b2b second");
      check("b2b overrun", overrun, 0);

      // reset mid-computation must abort with no output
      load_impulse_coefs();
      do_reset(2);
      strobe(32768);
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         data_en = 1'b0;
      end
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      hist.delete();
      cnt = 0;
      for (int j = 0; j < 80; j++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("abort no out_valid", cnt, 0);
      check("abort data_out", sdo(), 0);
      for (int i = 0; i < 71; i++) send(pos_vec[i].x, 1'b1, pos_vec[i].exp, "impulse after abort");

      for (int k = 0; k < NT; k++) coef_mem[k] = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 262143)) - 131072, 1'b0, 0, "random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
